div_requester: RTL and testbench
================================

DIV_REQUESTER -- requirements
Module: div_requester

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of wait cycles before a request is abandoned (used only with DIV_TIMEOUT_EN).
REQ-002 The block SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port wb_stb  input  1  bus access strobe, qualified by wb_cyc.
REQ-005 The block SHALL have port wb_cyc  input  1  bus cycle valid.
REQ-006 The block SHALL have port wb_we  input  1  write enable.
REQ-007 The block SHALL have port wb_adr  input  4  byte address; bits [3:2] select the register, and bits [1:0] are ignored.
REQ-008 The block SHALL have port wb_dat_i  input  32  write data.
REQ-009 The block SHALL have port wb_dat_o  output  32  read data, registered.
REQ-010 The block SHALL have port wb_ack  output  1  single-cycle acknowledge.
REQ-011 The block SHALL have ports div_dv  output  32  dividend and div_dr  output  32  divisor, both to the divider core.
REQ-012 The block SHALL have port div_init  output  1  start request to the divider core.
REQ-013 The block SHALL have ports div_ready  input  1  divider result-valid level and div_result  input  32  divider quotient.

Function
REQ-014 Register map: 0x0 DV (RW), 0x4 DR (RW), 0x8 CTRL/STATUS, 0xC RESULT (RO; writes are acked and discarded).
REQ-015 CTRL/STATUS read SHALL return bit0 busy, bit1 done, bit2 timeout, bit3 div_by_zero, and zeros in bits [31:4].
REQ-016 Writing CTRL with wb_dat_i[0]=1 SHALL start a request; writing bit0=0 SHALL only clear the done, timeout and div_by_zero bits.
REQ-017 wb_ack SHALL assert exactly one cycle after a cycle with wb_cyc&wb_stb&!wb_ack, for one cycle, and read data SHALL be valid in the same cycle as wb_ack.
REQ-018 div_dv and div_dr SHALL continuously drive the DV and DR registers.
REQ-019 Writes to DV or DR while busy SHALL be acked and ignored, and a start while busy SHALL be ignored.
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT and CAPTURE.
REQ-021 On a start in IDLE with DR!=0, the FSM SHALL go to ISSUE, set busy and clear done, timeout and div_by_zero.
REQ-022 On a start in IDLE with DR==0, the block SHALL set RESULT=0xFFFFFFFF, done=1 and div_by_zero=1 on the next cycle, stay in IDLE and never assert div_init.
REQ-023 In ISSUE, div_init SHALL be high for exactly one cycle, and the FSM SHALL then go to WAIT; div_init SHALL be low in all other states.
REQ-024 WAIT SHALL register div_ready into ready_q and SHALL advance to CAPTURE on a rising edge (div_ready=1 with ready_q=0); a ready level already high on entry SHALL NOT complete the request.
REQ-025 CAPTURE SHALL latch div_result into RESULT, set done=1, clear busy and return to IDLE, one cycle after the ready edge is detected.
REQ-026 A CTRL read in the same cycle as the CAPTURE update SHALL return the pre-update status.

Reset
REQ-027 While reset=1, the block SHALL set: FSM=IDLE; DV, DR, RESULT and wb_dat_o to 0; wb_ack=0; div_init=0; busy, done, timeout, div_by_zero and ready_q to 0; timeout counter to 0.
REQ-028 Reset during ISSUE or WAIT SHALL abandon the request without a further div_init pulse, and a late div_ready edge after reset SHALL NOT alter RESULT.

Configuration
REQ-029 With macro DIV_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 With DIV_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without a ready edge, the block SHALL set timeout=1, clear busy, leave RESULT unchanged and return to IDLE.
REQ-031 Without DIV_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL wait indefinitely, and status bit2 SHALL read 0.

Verification
REQ-032 DV=100, DR=7, start, model core raises ready 66 cycles after init -> one-cycle div_init pulse, then RESULT=14, status=0x2.
REQ-033 DV=0xFFFFFFFF, DR=1, start -> RESULT=0xFFFFFFFF, done=1, div_by_zero=0.
REQ-034 DR=0, start -> no div_init, RESULT=0xFFFFFFFF, status=0xA one cycle later.
REQ-035 Start, then write DV=5 and a second start while busy -> DV still holds the old value, only one div_init pulse, both writes acked.
REQ-036 DIV_TIMEOUT_EN defined, div_ready held 0 -> status=0x4 at 255 WAIT cycles, busy=0, RESULT unchanged.
REQ-037 Reset asserted mid-WAIT, then div_ready edge -> all status=0, RESULT=0, div_init stays 0.

Source files
------------

// File: rtl/div_requester.sv
// Wishbone-style register front end that feeds operands to a divider core and collects its quotient.
// Optional DIV_TIMEOUT_EN adds a WAIT-state watchdog that abandons the request after TIMEOUT_CYCLES.
module div_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic        wb_we,
  input  logic [3:0]  wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack,
  output logic [31:0] div_dv,
  output logic [31:0] div_dr,
  output logic        div_init,
  input  logic        div_ready,
  input  logic [31:0] div_result
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

  state_e      state_q;
  logic [31:0] dv_q, dr_q, result_q, rdata;
  logic        busy_q, done_q, timeout_q, dbz_q, ready_q;
  logic        access, wr, ctrl_wr;
  logic [1:0]  reg_sel;
  logic        unused_adr;

`ifdef DIV_TIMEOUT_EN
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 32'd1);
  logic [7:0] cnt_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign access     = wb_cyc & wb_stb & ~wb_ack;
  assign wr         = access & wb_we;
  assign reg_sel    = wb_adr[3:2];
  assign ctrl_wr    = wr & (reg_sel == 2'd2);
  assign unused_adr = ^wb_adr[1:0];
  assign div_dv     = dv_q;
  assign div_dr     = dr_q;

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      2'd0:    rdata = dv_q;
      2'd1:    rdata = dr_q;
      2'd2:    rdata = {28'd0, dbz_q, timeout_q, done_q, busy_q};
      default: rdata = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dv_q      <= 32'd0;
      dr_q      <= 32'd0;
      result_q  <= 32'd0;
      wb_dat_o  <= 32'd0;
      wb_ack    <= 1'b0;
      div_init  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      dbz_q     <= 1'b0;
      ready_q   <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      wb_ack   <= access;
      ready_q  <= div_ready;
      div_init <= 1'b0;
      // Read data reflects register values before this edge's updates.
      if (access) wb_dat_o <= rdata;

      if (wr && (state_q == StIdle)) begin
        if (reg_sel == 2'd0) dv_q <= wb_dat_i;
        if (reg_sel == 2'd1) dr_q <= wb_dat_i;
      end

      if (ctrl_wr && !wb_dat_i[0]) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        dbz_q     <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (ctrl_wr && wb_dat_i[0]) begin
            timeout_q <= 1'b0;
            if (dr_q != 32'd0) begin
              state_q  <= StIssue;
              div_init <= 1'b1;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              dbz_q    <= 1'b0;
            end else begin
              result_q <= 32'hFFFF_FFFF;
              done_q   <= 1'b1;
              dbz_q    <= 1'b1;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef DIV_TIMEOUT_EN
          cnt_q   <= 8'd0;
`endif
        end
        StWait: begin
          // Only a fresh rising edge completes; a level held over from before does not.
          if (div_ready && !ready_q) begin
            state_q <= StCapture;
          end
`ifdef DIV_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        StCapture: begin
          result_q <= div_result;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_requester.sv
// Scoreboard bench for div_requester: a behavioural divider core answers div_init pulses and
// expected quotients are queued at start and compared when the request completes.
module tb_div_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_stb, wb_cyc, wb_we;
  logic [3:0]  wb_adr;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack;
  logic [31:0] div_dv, div_dr;
  logic        div_init;
  logic        div_ready;
  logic [31:0] div_result;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  int init_cnt = 0, init_run = 0, init_max = 0;
  int core_delay = 66;
  bit core_hold = 1'b0, manual_mode = 1'b0, manual_level = 1'b0;

  always #5 clk = ~clk;

  div_requester dut (
    .clk        (clk),
    .reset      (reset),
    .wb_stb     (wb_stb),
    .wb_cyc     (wb_cyc),
    .wb_we      (wb_we),
    .wb_adr     (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack     (wb_ack),
    .div_dv     (div_dv),
    .div_dr     (div_dr),
    .div_init   (div_init),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    bit ok = 1'b0;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = wdata;
    rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack) begin
        ok = 1'b1;
        rdata = wb_dat_o;
        break;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    check_eq(we ? "ack_wr" : "ack_rd", 32'(ok), 32'd1);
  endtask

  task automatic bus_write(input logic [3:0] adr, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(1'b1, adr, data, dummy);
  endtask

  task automatic bus_read(input logic [3:0] adr, output logic [31:0] data);
    bus_xfer(1'b0, adr, 32'd0, data);
  endtask

  task automatic wait_done(output logic [31:0] st);
    for (int i = 0; i < 100; i++) begin
      bus_read(4'h8, st);
      if (!st[0]) break;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] dv, input logic [31:0] dr);
    logic [31:0] st, res, exp_res;
    int n0;
    bus_write(4'h0, dv);
    bus_write(4'h4, dr);
    check_eq({tag, "_div_dv"}, div_dv, dv);
    check_eq({tag, "_div_dr"}, div_dr, dr);
    n0 = init_cnt;
    init_max = 0;
    exp_res = (dr == 32'd0) ? 32'hFFFF_FFFF : dv / dr;
    bus_write(4'h8, 32'd1);
    exp_q.push_back(exp_res);
    bus_read(4'h8, st);
    check_eq({tag, "_status_after_start"}, st, (dr == 32'd0) ? 32'hA : 32'h1);
    wait_done(st);
    check_eq({tag, "_status_done"}, st, (dr == 32'd0) ? 32'hA : 32'h2);
    bus_read(4'hC, res);
    if (exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      check_eq({tag, "_result"}, res, last_res);
    end
    check_eq({tag, "_init_pulses"}, 32'(init_cnt - n0), (dr == 32'd0) ? 32'd0 : 32'd1);
    check_eq({tag, "_init_width"}, 32'(init_max), (dr == 32'd0) ? 32'd0 : 32'd1);
  endtask

  // Behavioural divider core, evaluated on the falling edge.
  initial begin
    logic [31:0] a, b;
    bit pend;
    int left, hold_left;
    pend = 1'b0; left = 0; hold_left = 0; a = 0; b = 0;
    div_ready = 1'b0;
    div_result = 32'd0;
    forever begin
      @(negedge clk);
      if (div_init) begin
        init_cnt++;
        init_run++;
        if (init_run > init_max) init_max = init_run;
      end else begin
        init_run = 0;
      end
      if (manual_mode) begin
        pend = 1'b0;
        div_ready = manual_level;
      end else if (div_init) begin
        a = div_dv; b = div_dr; pend = 1'b1; left = core_delay;
      end else if (div_ready) begin
        hold_left--;
        if (hold_left <= 0) div_ready = 1'b0;
      end else if (pend && !core_hold) begin
        left--;
        if (left <= 0) begin
          div_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
          div_ready = 1'b1;
          hold_left = 3;
          pend = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] st, rd;
    int n0;
    reset = 1'b1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_adr = 4'h0; wb_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_div_init", 32'(div_init), 32'd0);
    check_eq("rst_wb_ack", 32'(wb_ack), 32'd0);
    check_eq("rst_wb_dat_o", wb_dat_o, 32'd0);
    reset = 1'b0;
    bus_read(4'h0, rd); check_eq("rst_dv", rd, 32'd0);
    bus_read(4'h4, rd); check_eq("rst_dr", rd, 32'd0);
    bus_read(4'h8, rd); check_eq("rst_status", rd, 32'd0);
    bus_read(4'hC, rd); check_eq("rst_result", rd, 32'd0);

    core_delay = 66;
    run_div("basic", 32'd100, 32'd7);
    run_div("allones", 32'hFFFF_FFFF, 32'd1);

    bus_write(4'hC, 32'h1234_5678);
    bus_read(4'hC, rd); check_eq("result_ro", rd, last_res);
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, rd); check_eq("ctrl_clear", rd, 32'd0);

    run_div("divzero", 32'd55, 32'd0);
    bus_write(4'h8, 32'd0);
    bus_read(4'h8, rd); check_eq("divzero_clear", rd, 32'd0);

    for (int k = 0; k < 3; k++) begin
      core_delay = $urandom_range(2, 40);
      run_div("rand", $urandom(), 32'($urandom_range(1, 32'hFFFF)));
    end

    // Writes and a second start while busy must be ignored.
    core_delay = 30;
    bus_write(4'h0, 32'd100);
    bus_write(4'h4, 32'd7);
    n0 = init_cnt;
    bus_write(4'h8, 32'd1);
    exp_q.push_back(32'd14);
    bus_write(4'h0, 32'd5);
    bus_write(4'h4, 32'd9);
    bus_write(4'h8, 32'd1);
    bus_read(4'h0, rd); check_eq("busy_dv_kept", rd, 32'd100);
    bus_read(4'h4, rd); check_eq("busy_dr_kept", rd, 32'd7);
    wait_done(st);
    check_eq("busy_status", st, 32'h2);
    bus_read(4'hC, rd);
    if (exp_q.size() > 0) begin
      last_res = exp_q.pop_front();
      check_eq("busy_result", rd, last_res);
    end
    check_eq("busy_init_pulses", 32'(init_cnt - n0), 32'd1);

    // Core that never answers.
    core_hold = 1'b1;
    bus_write(4'h8, 32'd1);
`ifdef DIV_TIMEOUT_EN
    repeat (254) @(posedge clk);
    #1;
    bus_read(4'h8, rd); check_eq("to_before", rd, 32'h1);
    bus_read(4'h8, rd); check_eq("to_status", rd, 32'h4);
    bus_read(4'hC, rd); check_eq("to_result_kept", rd, last_res);
    bus_write(4'h8, 32'd1);
    repeat (20) @(posedge clk);
`else
    repeat (300) @(posedge clk);
    #1;
    bus_read(4'h8, rd); check_eq("hang_status", rd, 32'h1);
`endif

    // Reset mid-WAIT, then a late ready edge.
    manual_mode = 1'b1;
    manual_level = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    core_hold = 1'b0;
    n0 = init_cnt;
    repeat (2) @(posedge clk);
    manual_level = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_wait_init_low", 32'(div_init), 32'd0);
    bus_read(4'h8, rd); check_eq("rst_wait_status", rd, 32'd0);
    bus_read(4'hC, rd); check_eq("rst_wait_result", rd, 32'd0);
    bus_read(4'h0, rd); check_eq("rst_wait_dv", rd, 32'd0);
    check_eq("rst_wait_init_pulses", 32'(init_cnt - n0), 32'd0);
    manual_mode = 1'b0;

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
